// File: rtl/sample_feeder_pkg.sv
// Shared definitions for the sample feeder: FSM encodings and default sizes.
// Widths track the interpolator's 15-bit v_in and the 16-bit host PCM bus.
package sample_feeder_pkg;

    localparam int FEED_IN_BITS   = 16;
    localparam int FEED_OUT_BITS  = 15;
    localparam int FEED_DEPTH     = 16;
    localparam int FEED_PRIME_LVL = 8;

    typedef enum logic [1:0] {
        FEED_IDLE     = 2'd0,
        FEED_PRIME    = 2'd1,
        FEED_STREAM   = 2'd2,
        FEED_UNDERRUN = 2'd3
    } feed_state_t;

endpackage

// File: rtl/sample_fifo.sv
// Single-clock FIFO with registered pointers and level; no write-through bypass.
// Ports: ps_clock, reset (sync, high), push/wr_data, pop/rd_data, level, full, empty.
module sample_fifo
    import sample_feeder_pkg::*;
#(
    parameter int W     = FEED_IN_BITS,
    parameter int DEPTH = FEED_DEPTH,
    parameter int AW    = $clog2(DEPTH),
    parameter int LW    = $clog2(DEPTH) + 1
) (
    input  logic          ps_clock,
    input  logic          reset,
    input  logic          push,
    input  logic [W-1:0]  wr_data,
    input  logic          pop,
    output logic [W-1:0]  rd_data,
    output logic [LW-1:0] level,
    output logic          full,
    output logic          empty
);

    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (level == DEPTH_L);
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    // Storage is not reset; the pointers alone define valid contents.
    always_ff @(posedge ps_clock) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointer width equals log2(DEPTH), so wrap is the natural overflow.
    always_ff @(posedge ps_clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/sample_feeder.sv
// Host PCM -> interpolator v_in feeder: FIFO, prime/stream/underrun FSM, round+saturate.
// Ports: ps_clock, reset (sync, high), start, s_valid/s_data/s_ready (host side),
//        v_in_o (registered sample), state_o, fifo_level, underrun_cnt (saturating).
// Build option SAMPLE_FEEDER_ZERO_ON_UNDERRUN_EN: zero v_in_o from underrun until next pop.
module sample_feeder
    import sample_feeder_pkg::*;
#(
    parameter int IN_W      = FEED_IN_BITS,
    parameter int OUT_W     = FEED_OUT_BITS,
    parameter int DEPTH     = FEED_DEPTH,
    parameter int PRIME_LVL = FEED_PRIME_LVL
) (
    input  logic                     ps_clock,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     s_valid,
    input  logic [IN_W-1:0]          s_data,
    output logic                     s_ready,
    output logic [OUT_W-1:0]         v_in_o,
    output logic [1:0]               state_o,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [15:0]              underrun_cnt
);

    localparam int LW = $clog2(DEPTH) + 1;

    localparam logic [LW-1:0] PRIME_L = LW'(PRIME_LVL);

    localparam logic signed [IN_W:0] SAT_MAX =
        (IN_W+1)'((1 <<< (OUT_W-1)) - 1);
    localparam logic signed [IN_W:0] SAT_MIN =
        (IN_W+1)'(-(1 <<< (OUT_W-1)));

    feed_state_t state;
    feed_state_t state_nxt;

    logic             fifo_full;
    logic             fifo_empty;
    logic [IN_W-1:0]  fifo_rd;
    logic             push;
    logic             pop;
    logic             underrun_evt;
    logic             go_idle;

    logic signed [IN_W:0] rnd;
    logic signed [IN_W:0] half;
    logic [OUT_W-1:0]     conv;

    assign s_ready = !fifo_full && !reset;
    assign push    = s_valid && s_ready;
    assign state_o = state;

    sample_fifo #(
        .W     (IN_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .ps_clock (ps_clock),
        .reset    (reset),
        .push     (push),
        .wr_data  (s_data),
        .pop      (pop),
        .rd_data  (fifo_rd),
        .level    (fifo_level),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_ff @(posedge ps_clock) begin
        if (reset) begin
            state <= FEED_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            FEED_IDLE: begin
                if (start) state_nxt = FEED_PRIME;
            end
            FEED_PRIME: begin
                if (!start)                     state_nxt = FEED_IDLE;
                else if (fifo_level >= PRIME_L) state_nxt = FEED_STREAM;
            end
            FEED_STREAM: begin
                if (!start)          state_nxt = FEED_IDLE;
                else if (fifo_empty) state_nxt = FEED_UNDERRUN;
            end
            FEED_UNDERRUN: begin
                state_nxt = start ? FEED_PRIME : FEED_IDLE;
            end
            default: state_nxt = FEED_IDLE;
        endcase
    end

    // Stop takes priority over both pop and underrun in STREAM.
    always_comb begin
        pop          = 1'b0;
        underrun_evt = 1'b0;
        go_idle      = (state_nxt == FEED_IDLE);
        if (state == FEED_STREAM && start) begin
            pop          = !fifo_empty;
            underrun_evt = fifo_empty;
        end
    end

    // Round half up in IN_W+1 bits, then clamp; only 0x7FFF actually overflows.
    always_comb begin
        rnd  = {fifo_rd[IN_W-1], fifo_rd} + (IN_W+1)'(1);
        half = rnd >>> 1;
        conv = half[OUT_W-1:0];
        if (half > SAT_MAX) begin
            conv = SAT_MAX[OUT_W-1:0];
        end else if (half < SAT_MIN) begin
            conv = SAT_MIN[OUT_W-1:0];
        end
    end

    always_ff @(posedge ps_clock) begin
        if (reset) begin
            v_in_o <= '0;
        end else if (go_idle) begin
            v_in_o <= '0;
        end else if (pop) begin
            v_in_o <= conv;
`ifdef SAMPLE_FEEDER_ZERO_ON_UNDERRUN_EN
        end else if (underrun_evt) begin
            v_in_o <= '0;
`endif
        end
    end

    always_ff @(posedge ps_clock) begin
        if (reset) begin
            underrun_cnt <= '0;
        end else if (underrun_evt && underrun_cnt != 16'hFFFF) begin
            underrun_cnt <= underrun_cnt + 16'd1;
        end
    end

endmodule
